data_io_dl: RTL and testbench
=============================

Name: data_io_dl

Overview:
- Parametrised successor of the MiST io-controller download port.
- Receives file downloads over the io controller SPI link (UIO_FILE_TX, UIO_FILE_TX_DAT, and the new UIO_FILE_INDEX) and drives a write bus entirely in the core `clk` domain.
- The core supplies its own RAM/SDRAM; no embedded RAM, no second clock domain.
- Adds:
  - configurable data and address widths;
  - a file index, so one block serves several ROM/cartridge slots;
  - odd-byte flush and byte count reporting.

Parameters:
- START_ADDR, 0, word address loaded at download start
- ADDR_WIDTH, 16, width of ioctl_addr (word address)
- DATA_WIDTH, 8, write word width; legal values 8 or 16
- INDEX_WIDTH, 8, width of ioctl_index

Ports:
- clk  in  1  core clock; must be at least 4x the sck frequency
- reset  in  1  asynchronous, active-high
- sck  in  1  SPI clock from io controller (asynchronous)
- ss  in  1  SPI select, active high = deselected (asynchronous)
- sdi  in  1  SPI data in, MSB first (asynchronous)
- downloading  out  1  download active
- ioctl_index  out  INDEX_WIDTH  file index of current or last download
- ioctl_wr  out  1  one-cycle write strobe
- ioctl_addr  out  ADDR_WIDTH  word address for the ioctl_wr write
- ioctl_dout  out  DATA_WIDTH  write data; first byte in bits [7:0]
- size  out  32  bytes received in the current or last download

Behaviour:
- Reset values:
  - downloading=0, ioctl_index=0, ioctl_wr=0.
  - ioctl_addr=START_ADDR, ioctl_dout=0, size=0.
  - Bit counter and lane pointer at 0.
- Input sync:
  - sck, ss and sdi each pass through a 2-FF synchroniser.
  - sck rising edge = synchronised sck 0->1 between consecutive clk cycles.
  - sdi is sampled on that same cycle.
- Framing:
  - Synchronised ss=1 clears the bit counter and the "command seen" flag immediately. A partial byte is discarded.
  - Bits shift in MSB first. The 8th rising edge completes a byte.
  - The first byte after ss falls is the command. Every later byte in that frame is payload for that command.
- 0x53 UIO_FILE_TX, payload byte bit0:
  - bit0=1: ioctl_addr<=START_ADDR, size<=0, lane<=0, downloading<=1.
  - bit0=0: if DATA_WIDTH=16 and lane=1, first flush the pending byte as a word with upper byte 0x00 (ioctl_wr pulse, size unchanged). Then downloading<=0.
- 0x54 UIO_FILE_TX_DAT: each payload byte is ignored unless downloading=1.
  - DATA_WIDTH=8: ioctl_dout<=byte, ioctl_wr=1 for exactly one cycle.
  - DATA_WIDTH=16: lane 0 stores the byte as the low byte. Lane 1 sets ioctl_dout={byte,low} and pulses ioctl_wr.
  - size increments by 1 on every accepted byte.
- 0x55 UIO_FILE_INDEX: payload byte[INDEX_WIDTH-1:0] -> ioctl_index. Ignored while downloading=1.
- Any other command: payload ignored.
- Timing and address rules:
  - ioctl_wr rises on the clk cycle after the completing sck edge is detected.
  - ioctl_addr and ioctl_dout are stable while ioctl_wr=1.
  - ioctl_addr increments on the cycle after each ioctl_wr and wraps modulo 2^ADDR_WIDTH without error.
  - size saturates at 2^32-1.
- Boundary cases:
  - A write strobe and a start command can never coincide: bytes are at least 8 sck edges apart.
  - ss rising mid-download does not clear downloading; only 0x53 with bit0=0 or reset does.
  - Reset mid-download returns all state to reset values within the same cycle (asynchronous).

Optional Feature:
- Macro: DATA_IO_DL_CHECKSUM_EN.
- When defined:
  - Adds output port checksum (16 bits).
  - Cleared at download start.
  - Adds each accepted byte (mod 2^16).
  - Frozen and readable after download end.
- When undefined: the port and adder are absent; all other behaviour is identical.

Decomposition:
- Package data_io_pkg holds:
  - command constants UIO_FILE_TX=8'h53, UIO_FILE_TX_DAT=8'h54, UIO_FILE_INDEX=8'h55;
  - a typedef for the byte type.
- One natural sub-module, spi_byte_rx: synchroniser, edge detect, bit counter and shift register. Outputs: byte_valid pulse, byte value, first_byte flag.
- Command decode and the write/pack logic stay in data_io_dl.

Test Plan:
- Index then 8-bit download: cmd 0x55, payload 0x03; then 0x53/0x01; 0x54 with bytes 0xAA,0x55,0x12; then 0x53/0x00.
  -> ioctl_index=3; three ioctl_wr pulses at addr 0,1,2 with data AA,55,12; size=3; downloading 1->0.
- DATA_WIDTH=16 odd count: bytes 0x11,0x22,0x33 then end.
  -> writes 0x2211 @0 and 0x0033 @1; size=3.
- Wrap: ADDR_WIDTH=2, START_ADDR=3, two bytes.
  -> writes at addr 3 then 0.
- Ignore rules:
  - 0x54 bytes with downloading=0 -> no ioctl_wr.
  - 0x55 while downloading -> ioctl_index unchanged.
- Abort: ss high after 5 bits of a data byte, then a fresh byte.
  -> partial bits discarded, next full byte written correctly; async reset mid-download -> downloading=0, ioctl_wr=0 immediately.
- Checksum (macro on): bytes 0xFF,0x02.
  -> checksum=0x0101 after end.

Source files
------------

// File: rtl/data_io_pkg.sv
// Shared types and io-controller command codes for the file download port.
package data_io_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t UIO_FILE_TX     = 8'h53;
  localparam byte_t UIO_FILE_TX_DAT = 8'h54;
  localparam byte_t UIO_FILE_INDEX  = 8'h55;

endpackage

// File: rtl/data_io_dl_spi_byte_rx.sv
// SPI byte receiver: synchronises sck/ss/sdi into clk, shifts bits MSB first and
// flags each completed byte, marking the first byte of a frame as the command.
module spi_byte_rx
  import data_io_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  sck,
  input  logic  ss,
  input  logic  sdi,
  output logic  byte_valid,
  output byte_t rx_byte,
  output logic  first_byte
);

  logic [1:0] sck_sync;
  logic [1:0] ss_sync;
  logic [1:0] sdi_sync;
  logic       sck_d;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       cmd_seen;
  logic       sck_rise;

  assign sck_rise = sck_sync[1] & ~sck_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync <= '0;
      ss_sync  <= '0;
      sdi_sync <= '0;
      sck_d    <= 1'b0;
      bit_cnt  <= '0;
      shift    <= '0;
      cmd_seen <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], sck};
      ss_sync  <= {ss_sync[0], ss};
      sdi_sync <= {sdi_sync[0], sdi};
      sck_d    <= sck_sync[1];
      // Deselect drops any partial byte and re-arms command detection.
      if (ss_sync[1]) begin
        bit_cnt  <= '0;
        cmd_seen <= 1'b0;
      end else if (sck_rise) begin
        shift   <= {shift[5:0], sdi_sync[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7)
          cmd_seen <= 1'b1;
      end
    end
  end

  // Byte is presented combinationally on the completing edge so the top can
  // register its write strobe one cycle later.
  assign byte_valid = sck_rise & ~ss_sync[1] & (bit_cnt == 3'd7);
  assign rx_byte    = {shift, sdi_sync[1]};
  assign first_byte = ~cmd_seen;

endmodule

// File: rtl/data_io_dl.sv
// io-controller file download port: decodes file commands and drives a word write bus.
// Optional checksum output enabled by defining DATA_IO_DL_CHECKSUM_EN.
module data_io_dl
  import data_io_pkg::*;
#(
  parameter int START_ADDR  = 0,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sck,
  input  logic                   ss,
  input  logic                   sdi,
  output logic                   downloading,
  output logic [INDEX_WIDTH-1:0] ioctl_index,
  output logic                   ioctl_wr,
  output logic [ADDR_WIDTH-1:0]  ioctl_addr,
  output logic [DATA_WIDTH-1:0]  ioctl_dout,
  output logic [31:0]            size
`ifdef DATA_IO_DL_CHECKSUM_EN
  ,
  output logic [15:0]            checksum
`endif
);

  localparam logic                  IS16  = (DATA_WIDTH == 16);
  localparam logic [ADDR_WIDTH-1:0] START = ADDR_WIDTH'(START_ADDR);

  logic                  byte_valid;
  byte_t                 rx_byte;
  logic                  first_byte;
  byte_t                 cmd;
  byte_t                 low_byte;
  logic                  lane;
  logic [DATA_WIDTH-1:0] word_data;
  logic [DATA_WIDTH-1:0] flush_data;
  logic                  payload_vld;

  spi_byte_rx u_rx (
    .clk        (clk),
    .reset      (reset),
    .sck        (sck),
    .ss         (ss),
    .sdi        (sdi),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .first_byte (first_byte)
  );

  generate
    if (DATA_WIDTH == 16) begin : g_w16
      assign word_data  = {rx_byte, low_byte};
      assign flush_data = {8'h00, low_byte};
    end else begin : g_w8
      assign word_data  = rx_byte;
      assign flush_data = low_byte;
    end
  endgenerate

  assign payload_vld = byte_valid & ~first_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      downloading <= 1'b0;
      ioctl_index <= '0;
      ioctl_wr    <= 1'b0;
      ioctl_addr  <= START;
      ioctl_dout  <= '0;
      size        <= '0;
      cmd         <= '0;
      low_byte    <= '0;
      lane        <= 1'b0;
`ifdef DATA_IO_DL_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      ioctl_wr <= 1'b0;
      // Address advances after each strobe so it is stable while ioctl_wr is high.
      if (ioctl_wr)
        ioctl_addr <= ioctl_addr + 1'b1;
      if (byte_valid && first_byte)
        cmd <= rx_byte;
      if (payload_vld) begin
        case (cmd)
          UIO_FILE_TX: begin
            if (rx_byte[0]) begin
              ioctl_addr  <= START;
              size        <= '0;
              lane        <= 1'b0;
              downloading <= 1'b1;
`ifdef DATA_IO_DL_CHECKSUM_EN
              checksum    <= '0;
`endif
            end else begin
              if (IS16 && lane) begin
                ioctl_dout <= flush_data;
                ioctl_wr   <= 1'b1;
                lane       <= 1'b0;
              end
              downloading <= 1'b0;
            end
          end
          UIO_FILE_TX_DAT: begin
            if (downloading) begin
              if (IS16 && !lane) begin
                low_byte <= rx_byte;
                lane     <= 1'b1;
              end else begin
                ioctl_dout <= word_data;
                ioctl_wr   <= 1'b1;
                lane       <= 1'b0;
              end
              if (size != 32'hFFFF_FFFF)
                size <= size + 32'd1;
`ifdef DATA_IO_DL_CHECKSUM_EN
              checksum <= checksum + 16'(rx_byte);
`endif
            end
          end
          UIO_FILE_INDEX: begin
            if (!downloading)
              ioctl_index <= INDEX_WIDTH'(rx_byte);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_io_dl.sv
// Scoreboard bench for data_io_dl: 8-bit, 16-bit and wrapping 2-bit-address instances
// share one SPI stimulus; each instance's writes are checked against its own queue.
module tb_data_io_dl;
  import data_io_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sck = 1'b0;
  logic ss = 1'b1;
  logic sdi = 1'b0;

  always #5 clk = ~clk;

  logic        dl8, dl16, dlw;
  logic [7:0]  idx8, idx16, idxw;
  logic        wr8, wr16, wrw;
  logic [15:0] a8, a16;
  logic [1:0]  aw;
  logic [7:0]  d8, dw;
  logic [15:0] d16;
  logic [31:0] sz8, sz16, szw;
`ifdef DATA_IO_DL_CHECKSUM_EN
  logic [15:0] cs8, cs16, csw;
`endif

  data_io_dl #(.START_ADDR(0), .ADDR_WIDTH(16), .DATA_WIDTH(8), .INDEX_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
    .downloading(dl8), .ioctl_index(idx8), .ioctl_wr(wr8), .ioctl_addr(a8),
    .ioctl_dout(d8), .size(sz8)
`ifdef DATA_IO_DL_CHECKSUM_EN
    , .checksum(cs8)
`endif
  );

  data_io_dl #(.START_ADDR(0), .ADDR_WIDTH(16), .DATA_WIDTH(16), .INDEX_WIDTH(8)) dut16 (
    .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
    .downloading(dl16), .ioctl_index(idx16), .ioctl_wr(wr16), .ioctl_addr(a16),
    .ioctl_dout(d16), .size(sz16)
`ifdef DATA_IO_DL_CHECKSUM_EN
    , .checksum(cs16)
`endif
  );

  data_io_dl #(.START_ADDR(3), .ADDR_WIDTH(2), .DATA_WIDTH(8), .INDEX_WIDTH(8)) dutw (
    .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
    .downloading(dlw), .ioctl_index(idxw), .ioctl_wr(wrw), .ioctl_addr(aw),
    .ioctl_dout(dw), .size(szw)
`ifdef DATA_IO_DL_CHECKSUM_EN
    , .checksum(csw)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected writes packed as {addr[15:0], data[15:0]}.
  logic [31:0] q8[$];
  logic [31:0] q16[$];
  logic [31:0] qw[$];

  logic        m_dl = 1'b0;
  logic [15:0] m_a8, m_a16;
  logic [1:0]  m_aw;
  logic        m_lane = 1'b0;
  logic [7:0]  m_low;
  logic [31:0] m_size = 0;

  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset) begin
      if (wr8) begin
        if (q8.size() == 0) check_eq("wr8_unexpected", {a8, 8'h00, d8}, 64'h0);
        else begin e = q8.pop_front(); check_eq("wr8", {a8, 8'h00, d8}, e); end
      end
      if (wr16) begin
        if (q16.size() == 0) check_eq("wr16_unexpected", {a16, d16}, 64'h0);
        else begin e = q16.pop_front(); check_eq("wr16", {a16, d16}, e); end
      end
      if (wrw) begin
        if (qw.size() == 0) check_eq("wrw_unexpected", {14'h0, aw, 8'h00, dw}, 64'h0);
        else begin e = qw.pop_front(); check_eq("wrw", {14'h0, aw, 8'h00, dw}, e); end
      end
    end
  end

  task automatic tx_byte(input byte_t b);
    for (int i = 7; i >= 0; i--) begin
      sdi = b[i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  task automatic frame_open();
    ss = 1'b0;
    #40;
  endtask

  task automatic frame_close();
    #40 ss = 1'b1;
    #120;
  endtask

  task automatic tx_data(input byte_t b);
    if (m_dl) begin
      q8.push_back({m_a8, 8'h00, b});
      m_a8 = m_a8 + 16'd1;
      qw.push_back({14'h0, m_aw, 8'h00, b});
      m_aw = m_aw + 2'd1;
      if (!m_lane) begin
        m_low  = b;
        m_lane = 1'b1;
      end else begin
        q16.push_back({m_a16, b, m_low});
        m_a16  = m_a16 + 16'd1;
        m_lane = 1'b0;
      end
      m_size++;
    end
    tx_byte(b);
  endtask

  task automatic send_cmd(input byte_t c, input byte_t p);
    if (c == UIO_FILE_TX && p[0]) begin
      m_dl = 1'b1; m_a8 = 16'd0; m_a16 = 16'd0; m_aw = 2'd3; m_lane = 1'b0; m_size = 0;
    end else if (c == UIO_FILE_TX && m_dl) begin
      if (m_lane) begin
        q16.push_back({m_a16, 8'h00, m_low});
        m_a16  = m_a16 + 16'd1;
        m_lane = 1'b0;
      end
      m_dl = 1'b0;
    end
    frame_open();
    tx_byte(c);
    tx_byte(p);
    frame_close();
  endtask

  task automatic check_all_drained(input string tag);
    check_eq({tag, "_q8"}, 64'(q8.size()), 64'd0);
    check_eq({tag, "_q16"}, 64'(q16.size()), 64'd0);
    check_eq({tag, "_qw"}, 64'(qw.size()), 64'd0);
  endtask

  initial begin
    #20;
    check_eq("rst_dl", {dl8, dl16, dlw}, 64'd0);
    check_eq("rst_idx", idx8, 64'd0);
    check_eq("rst_wr", {wr8, wr16, wrw}, 64'd0);
    check_eq("rst_addr8", a8, 64'd0);
    check_eq("rst_addrw", aw, 64'd3);
    check_eq("rst_dout", {d8, d16}, 64'd0);
    check_eq("rst_size", sz8, 64'd0);
    #3 reset = 1'b0;
    #40;

    // Data frame with no download active must not write.
    frame_open(); tx_byte(UIO_FILE_TX_DAT); tx_data(8'h77); frame_close();
    check_eq("ignore_dat_size", sz8, 64'd0);

    send_cmd(UIO_FILE_INDEX, 8'h03);
    check_eq("index_set", {idx8, idx16, idxw}, 64'h030303);

    send_cmd(UIO_FILE_TX, 8'h01);
    check_eq("start_dl", {dl8, dl16, dlw}, 64'h7);

    send_cmd(UIO_FILE_INDEX, 8'h09);
    check_eq("index_locked", idx8, 64'h03);

    frame_open(); tx_byte(UIO_FILE_TX_DAT);
    tx_data(8'hAA); tx_data(8'h55); tx_data(8'h12);
    frame_close();

    send_cmd(UIO_FILE_TX, 8'h00);
    check_eq("end_dl", {dl8, dl16, dlw}, 64'h0);
    check_eq("size8_a", sz8, 64'd3);
    check_eq("size16_a", sz16, 64'd3);
    check_eq("size_model_a", szw, 64'(m_size));
    check_all_drained("dl1");

    // Second download: first data frame aborted 5 bits into its second byte.
    send_cmd(UIO_FILE_TX, 8'h01);
    frame_open(); tx_byte(UIO_FILE_TX_DAT); tx_data(8'h11);
    for (int i = 0; i < 5; i++) begin
      sdi = i[0];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
    #40 ss = 1'b1;
    #120;
    check_eq("abort_size", sz8, 64'd1);
    frame_open(); tx_byte(UIO_FILE_TX_DAT); tx_data(8'h22); tx_data(8'h33); frame_close();
    send_cmd(UIO_FILE_TX, 8'h00);
    check_eq("size16_b", sz16, 64'd3);
    check_eq("dl_after_b", dl16, 64'd0);
    check_all_drained("dl2");

    // Third download for the checksum path.
    send_cmd(UIO_FILE_TX, 8'h01);
    frame_open(); tx_byte(UIO_FILE_TX_DAT); tx_data(8'hFF); tx_data(8'h02); frame_close();
    send_cmd(UIO_FILE_TX, 8'h00);
    check_eq("size_c", sz8, 64'd2);
`ifdef DATA_IO_DL_CHECKSUM_EN
    check_eq("checksum8", cs8, 64'h0101);
    check_eq("checksum16", cs16, 64'h0101);
`endif
    check_all_drained("dl3");

    // Asynchronous reset in the middle of a download.
    send_cmd(UIO_FILE_TX, 8'h01);
    frame_open(); tx_byte(UIO_FILE_TX_DAT); tx_data(8'h5A);
    #60;
    check_eq("pre_reset_dl", dl8, 64'd1);
    check_eq("pre_reset_size", sz8, 64'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_dl", {dl8, dl16, dlw}, 64'd0);
    check_eq("async_rst_wr", {wr8, wr16, wrw}, 64'd0);
    check_eq("async_rst_size", sz8, 64'd0);
    check_eq("async_rst_addrw", aw, 64'd3);
    check_eq("async_rst_idx", idx8, 64'd0);
    ss = 1'b1;
    q8.delete(); q16.delete(); qw.delete();
    m_dl = 1'b0; m_lane = 1'b0;
    #40;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
